// File: rtl/ms_dbio_arb.sv
// Round-robin arbiter that shares one DBIO master port among CReqCnt requesters.
// Each grant issues one command, waits for the slave (with timeout), then acks the requester.
module ms_dbio_arb #(
  parameter int CReqCnt  = 3,
  parameter int CTimeout = 255
) (
  input  logic                    AClkH,
  input  logic                    AResetHN,
  input  logic                    AClkHEn,
  input  logic [CReqCnt-1:0]      AReq,
  input  logic [12*CReqCnt-1:0]   AReqAddr,
  input  logic [64*CReqCnt-1:0]   AReqMosi,
  input  logic [4*CReqCnt-1:0]    AReqMosiIdx,
  input  logic [4*CReqCnt-1:0]    AReqMisoIdx,
  output logic [CReqCnt-1:0]      AAck,
  output logic                    AErr,
  output logic [63:0]             AMiso,
  output logic [11:0]             ADbioAddr,
  output logic [63:0]             ADbioMosi,
  output logic [3:0]              ADbioMosiIdx,
  output logic [3:0]              ADbioMisoIdx,
  output logic                    ADbioMosi1st,
  output logic                    ADbioMiso1st,
  input  logic [63:0]             ADbioMiso,
  input  logic                    ADbioBusy,
  output logic                    ABusy,
  output logic [1:0]              AGnt
);

  // state | meaning
  // Idle  | no transaction; arbitrate among raised requests
  // Issue | latched command driven on the DBIO port for one cycle
  // Wait  | waiting for the slave to drop busy, or for the timeout
  // Done  | one-cycle ack to the granted requester
  typedef enum logic [3:0] {
    stIdle  = 4'b0001,
    stIssue = 4'b0010,
    stWait  = 4'b0100,
    stDone  = 4'b1000
  } stateT;

  stateT       state, nextState;
  logic [11:0] cmdAddr, selAddr;
  logic [63:0] cmdMosi, selMosi;
  logic [3:0]  cmdMosiIdx, cmdMisoIdx, selMosiIdx, selMisoIdx;
  logic [1:0]  gntQ, rrPtr, selIdx, rrNext;
  logic        selFound;
  logic [7:0]  waitCnt;
  logic [63:0] misoQ;
  logic        errQ;
  logic        timeoutHit;

  // rrPtr holds the requester with highest priority for the next grant.
  always_comb begin
    selFound   = 1'b0;
    selIdx     = '0;
    rrNext     = '0;
    selAddr    = '0;
    selMosi    = '0;
    selMosiIdx = '0;
    selMisoIdx = '0;
    for (int off = 0; off < CReqCnt; off++) begin
      for (int i = 0; i < CReqCnt; i++) begin
        if (!selFound && AReq[i] && (i == (int'(rrPtr) + off) % CReqCnt)) begin
          selFound   = 1'b1;
          selIdx     = 2'(i);
          rrNext     = 2'((i + 1) % CReqCnt);
          selAddr    = AReqAddr[12*i +: 12];
          selMosi    = AReqMosi[64*i +: 64];
          selMosiIdx = AReqMosiIdx[4*i +: 4];
          selMisoIdx = AReqMisoIdx[4*i +: 4];
        end
      end
    end
  end

  assign timeoutHit = (waitCnt == 8'(CTimeout - 1));

  always_ff @(posedge AClkH or negedge AResetHN) begin
    if (!AResetHN) begin
      state <= stIdle;
    end else if (AClkHEn) begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      stIdle:  if (selFound) nextState = stIssue;
      stIssue: nextState = stWait;
      stWait:  if (!ADbioBusy || timeoutHit) nextState = stDone;
      stDone:  nextState = stIdle;
      default: nextState = stIdle;
    endcase
  end

  always_ff @(posedge AClkH or negedge AResetHN) begin
    if (!AResetHN) begin
      cmdAddr    <= '0;
      cmdMosi    <= '0;
      cmdMosiIdx <= '0;
      cmdMisoIdx <= '0;
      gntQ       <= '0;
      rrPtr      <= '0;
      waitCnt    <= '0;
      misoQ      <= '0;
      errQ       <= 1'b0;
    end else if (AClkHEn) begin
      case (state)
        stIdle: begin
          if (selFound) begin
            cmdAddr    <= selAddr;
            cmdMosi    <= selMosi;
            cmdMosiIdx <= selMosiIdx;
            cmdMisoIdx <= selMisoIdx;
            gntQ       <= selIdx;
            rrPtr      <= rrNext;
          end
        end
        stIssue: waitCnt <= '0;
        stWait: begin
          if (!ADbioBusy) begin
            misoQ <= ADbioMiso;
            errQ  <= 1'b0;
          end else if (timeoutHit) begin
            misoQ <= '0;
            errQ  <= 1'b1;
          end else begin
            waitCnt <= waitCnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // DBIO outputs are zero outside Issue so several masters can be OR-ed together.
  assign ADbioAddr    = (state == stIssue) ? cmdAddr : '0;
  assign ADbioMosi    = (state == stIssue) ? cmdMosi : '0;
  assign ADbioMosiIdx = (state == stIssue) ? cmdMosiIdx : '0;
  assign ADbioMisoIdx = (state == stIssue) ? cmdMisoIdx : '0;
  assign ADbioMosi1st = (state == stIssue) && (cmdMosiIdx != 4'd0);
  assign ADbioMiso1st = (state == stIssue) && (cmdMisoIdx != 4'd0);

  always_comb begin
    AAck = '0;
    for (int i = 0; i < CReqCnt; i++) begin
      AAck[i] = (state == stDone) && (gntQ == 2'(i));
    end
  end

  assign AErr  = errQ;
  assign AMiso = misoQ;
  assign ABusy = (state != stIdle);
  assign AGnt  = gntQ;

endmodule

// File: tb/tb_ms_dbio_arb.sv
// Bench for ms_dbio_arb: two instances (default timeout and timeout 4) share the stimulus,
// only the selected one sees requests; a transaction-level model predicts grants and latency.
module tb_ms_dbio_arb;
  localparam int N  = 3;
  localparam int TT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstN, en, selT;
  logic [2:0]  req, req0, reqT;
  logic [11:0] addrA [N];
  logic [63:0] mosiA [N];
  logic [3:0]  mosiIdxA [N], misoIdxA [N];
  logic [35:0] reqAddr;
  logic [191:0] reqMosi;
  logic [11:0] reqMosiIdx, reqMisoIdx;
  logic [63:0] dbioMiso;
  logic        dbioBusy;

  logic [2:0]  ack0, ackT;
  logic        err0, errT, busy0, busyT, m1st0, m1stT, s1st0, s1stT;
  logic [63:0] miso0, misoT, mosi0, mosiT;
  logic [11:0] addr0, addrT;
  logic [3:0]  mIdx0, mIdxT, sIdx0, sIdxT;
  logic [1:0]  gnt0, gntT;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      reqAddr[12*i +: 12]   = addrA[i];
      reqMosi[64*i +: 64]   = mosiA[i];
      reqMosiIdx[4*i +: 4]  = mosiIdxA[i];
      reqMisoIdx[4*i +: 4]  = misoIdxA[i];
    end
  end
  assign req0 = selT ? 3'b000 : req;
  assign reqT = selT ? req : 3'b000;

  ms_dbio_arb #(.CReqCnt(N), .CTimeout(255)) dut0 (
    .AClkH(clk), .AResetHN(rstN), .AClkHEn(en), .AReq(req0),
    .AReqAddr(reqAddr), .AReqMosi(reqMosi), .AReqMosiIdx(reqMosiIdx), .AReqMisoIdx(reqMisoIdx),
    .AAck(ack0), .AErr(err0), .AMiso(miso0),
    .ADbioAddr(addr0), .ADbioMosi(mosi0), .ADbioMosiIdx(mIdx0), .ADbioMisoIdx(sIdx0),
    .ADbioMosi1st(m1st0), .ADbioMiso1st(s1st0),
    .ADbioMiso(dbioMiso), .ADbioBusy(dbioBusy), .ABusy(busy0), .AGnt(gnt0));

  ms_dbio_arb #(.CReqCnt(N), .CTimeout(TT)) dutT (
    .AClkH(clk), .AResetHN(rstN), .AClkHEn(en), .AReq(reqT),
    .AReqAddr(reqAddr), .AReqMosi(reqMosi), .AReqMosiIdx(reqMosiIdx), .AReqMisoIdx(reqMisoIdx),
    .AAck(ackT), .AErr(errT), .AMiso(misoT),
    .ADbioAddr(addrT), .ADbioMosi(mosiT), .ADbioMosiIdx(mIdxT), .ADbioMisoIdx(sIdxT),
    .ADbioMosi1st(m1stT), .ADbioMiso1st(s1stT),
    .ADbioMiso(dbioMiso), .ADbioBusy(dbioBusy), .ABusy(busyT), .AGnt(gntT));

  logic [2:0]  obsAck;
  logic        obsErr, obsBusy, obsM1, obsS1, obsDbioAny;
  logic [63:0] obsMiso, obsMosi;
  logic [11:0] obsAddr;
  logic [3:0]  obsMIdx, obsSIdx;
  logic [1:0]  obsGnt;
  assign obsAck  = selT ? ackT  : ack0;
  assign obsErr  = selT ? errT  : err0;
  assign obsBusy = selT ? busyT : busy0;
  assign obsMiso = selT ? misoT : miso0;
  assign obsMosi = selT ? mosiT : mosi0;
  assign obsAddr = selT ? addrT : addr0;
  assign obsMIdx = selT ? mIdxT : mIdx0;
  assign obsSIdx = selT ? sIdxT : sIdx0;
  assign obsM1   = selT ? m1stT : m1st0;
  assign obsS1   = selT ? s1stT : s1st0;
  assign obsGnt  = selT ? gntT  : gnt0;
  assign obsDbioAny = |{obsAddr, obsMosi, obsMIdx, obsSIdx, obsM1, obsS1};

  int nTests = 0;
  int nFail  = 0;
  int rr [2];   // next highest-priority requester, per instance

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pickGrant(input logic [2:0] mask, input int start);
    logic [2:0] m;
    m = mask;
    for (int off = 0; off < N; off++) begin
      if (m[(start + off) % N]) return (start + off) % N;
    end
    return 0;
  endfunction

  // k = number of Wait cycles the slave stays busy; freezeAt = Wait cycle to stall the clock enable (0 = none).
  task automatic runTxn(input logic [2:0] mask, input int k, input logic [63:0] rdData,
                        input int freezeAt, input bit rnd);
    int g, waits, n, tmo;
    bit expErr, got;
    logic [63:0] expMiso;
    tmo = selT ? TT : 255;
    if (rnd) begin
      for (int i = 0; i < N; i++) begin
        addrA[i]    = 12'($urandom);
        mosiA[i]    = {$urandom, $urandom};
        mosiIdxA[i] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
        misoIdxA[i] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
      end
    end
    g = pickGrant(mask, rr[selT]);
    rr[selT] = (g + 1) % N;
    expErr  = (k >= tmo);
    waits   = expErr ? tmo : k + 1;
    expMiso = expErr ? 64'd0 : rdData;
    req = mask;
    dbioMiso = rdData;
    dbioBusy = 1'b0;
    @(negedge clk);
    chk("issueBusy", 64'(obsBusy), 64'd1);
    chk("issueGnt", 64'(obsGnt), 64'(g));
    chk("issueAddr", 64'(obsAddr), 64'(addrA[g]));
    chk("issueMosi", obsMosi, mosiA[g]);
    chk("issueMosiIdx", 64'(obsMIdx), 64'(mosiIdxA[g]));
    chk("issueMisoIdx", 64'(obsSIdx), 64'(misoIdxA[g]));
    chk("issueMosi1st", 64'(obsM1), 64'(mosiIdxA[g] != 4'd0));
    chk("issueMiso1st", 64'(obsS1), 64'(misoIdxA[g] != 4'd0));
    chk("issueAck", 64'(obsAck), 64'd0);
    n = 0;
    got = 1'b0;
    while (!got && n < 300) begin
      @(negedge clk);
      n++;
      if (obsAck != 3'b000) begin
        got = 1'b1;
      end else begin
        chk("waitDbioZero", 64'(obsDbioAny), 64'd0);
        chk("waitBusy", 64'(obsBusy), 64'd1);
        dbioBusy = (n - 1 < k);
        if (n == freezeAt) begin
          en = 1'b0;
          dbioBusy = ~dbioBusy;
          repeat (3) begin
            @(negedge clk);
            chk("frzAck", 64'(obsAck), 64'd0);
            chk("frzBusy", 64'(obsBusy), 64'd1);
            chk("frzGnt", 64'(obsGnt), 64'(g));
            chk("frzDbioZero", 64'(obsDbioAny), 64'd0);
          end
          dbioBusy = ~dbioBusy;
          en = 1'b1;
        end
      end
    end
    // cycles from Issue to Done: one for Issue itself plus the Wait cycles
    chk("doneLatency", 64'(n), 64'(waits + 1));
    chk("doneAck", 64'(obsAck), 64'(3'b001 << g));
    chk("doneErr", 64'(obsErr), 64'(expErr));
    chk("doneMiso", obsMiso, expMiso);
    chk("doneDbioZero", 64'(obsDbioAny), 64'd0);
    req = mask & ~(3'b001 << g);
    dbioBusy = 1'($urandom_range(0, 1));
    dbioMiso = {$urandom, $urandom};
    @(negedge clk);
    chk("idleBusy", 64'(obsBusy), 64'd0);
    chk("idleAck", 64'(obsAck), 64'd0);
    chk("holdMiso", obsMiso, expMiso);
    chk("holdErr", 64'(obsErr), 64'(expErr));
    chk("idleGnt", 64'(obsGnt), 64'(g));
  endtask

  initial begin
    rstN = 1'b0; en = 1'b1; selT = 1'b0; req = 3'b000;
    dbioBusy = 1'b0; dbioMiso = '0;
    rr[0] = 0; rr[1] = 0;
    for (int i = 0; i < N; i++) begin
      addrA[i] = '0; mosiA[i] = '0; mosiIdxA[i] = '0; misoIdxA[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      selT = 1'(s);
      #1;
      chk("rstBusy", 64'(obsBusy), 64'd0);
      chk("rstAck", 64'(obsAck), 64'd0);
      chk("rstErr", 64'(obsErr), 64'd0);
      chk("rstMiso", obsMiso, 64'd0);
      chk("rstGnt", 64'(obsGnt), 64'd0);
      chk("rstDbio", 64'(obsDbioAny), 64'd0);
    end
    selT = 1'b0;
    @(negedge clk);
    rstN = 1'b1;

    // round robin from reset: 0,1,2,0
    for (int t = 0; t < 4; t++) runTxn(3'b111, $urandom_range(0, 3), {$urandom, $urandom}, 0, 1'b1);

    // single request, zero wait
    addrA[0] = 12'h100; mosiA[0] = 64'h1; mosiIdxA[0] = 4'd2; misoIdxA[0] = 4'd0;
    runTxn(3'b001, 0, 64'h1234_5678, 0, 1'b0);

    // slave stall for 5 Wait cycles
    runTxn(3'b001, 5, 64'hDEAD, 0, 1'b1);

    // clock enable low for 3 cycles in Wait
    runTxn(3'b100, 3, 64'hCAFE, 2, 1'b1);
    runTxn(3'b010, 0, 64'hF00D, 1, 1'b1);

    // timeout instance: boundary just below, at and well past the limit, then a normal one
    selT = 1'b1;
    runTxn(3'b001, 3, 64'hA5A5, 0, 1'b1);
    runTxn(3'b001, 4, 64'hBEEF, 0, 1'b1);
    runTxn(3'b010, 50, 64'hBEEF, 3, 1'b1);
    runTxn(3'b010, 1, 64'h7777, 0, 1'b1);

    // reset during Wait
    selT = 1'b0;
    req = 3'b001;
    dbioBusy = 1'b1;
    dbioMiso = 64'h1111;
    repeat (3) @(negedge clk);
    chk("preRstBusy", 64'(obsBusy), 64'd1);
    rstN = 1'b0;
    req = 3'b010;
    #1;
    chk("midRstBusy", 64'(obsBusy), 64'd0);
    chk("midRstAck", 64'(obsAck), 64'd0);
    chk("midRstErr", 64'(obsErr), 64'd0);
    chk("midRstMiso", obsMiso, 64'd0);
    chk("midRstGnt", 64'(obsGnt), 64'd0);
    chk("midRstDbio", 64'(obsDbioAny), 64'd0);
    @(negedge clk);
    chk("midRstAck2", 64'(obsAck), 64'd0);
    rstN = 1'b1;
    rr[0] = 0; rr[1] = 0;
    runTxn(3'b010, 0, 64'h2222, 0, 1'b1);

    // randomized transactions on both instances
    for (int t = 0; t < 40; t++) begin
      selT = 1'($urandom_range(0, 1));
      runTxn(3'($urandom_range(1, 7)), $urandom_range(0, 6), {$urandom, $urandom},
             $urandom_range(0, 4), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
